image_row_server: RTL and testbench

IMAGE_ROW_SERVER -- requirements
Module: image_row_server

---
 rtl/image_row_server_pkg.sv | 15 +
 rtl/image_row_server_row_assembler.sv | 54 +++++
 rtl/image_row_server.sv | 108 ++++++++++
 tb/tb_image_row_server.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_row_server_pkg.sv
// Shared interpolation constants and the row-server state encoding.
// subpixel_interpolation imports this package as well.
package image_row_server_pkg;

  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 15;
  localparam int NUM_ROWS = 15;
  localparam int ROW_W    = PIX_W * ROW_PIX;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/image_row_server_row_assembler.sv
// Gathers raster-order samples into a row and strobes commit on the last column.
// row_o already carries the current sample so the commit edge stores a complete row.
module row_assembler #(
  parameter int PIX_W   = image_row_server_pkg::PIX_W,
  parameter int ROW_PIX = image_row_server_pkg::ROW_PIX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     accept_i,
  input  logic [PIX_W-1:0]         pix_i,
  output logic [PIX_W*ROW_PIX-1:0] row_o,
  output logic                     commit_o
);
  localparam int COL_W = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [PIX_W-1:0] stage_q [ROW_PIX];
  logic             last_col;

  assign last_col = (col_q == COL_W'(ROW_PIX - 1));
  assign commit_o = accept_i && last_col;

  always_comb begin
    col_d = col_q;
    if (clear_i) begin
      col_d = '0;
    end else if (accept_i) begin
      col_d = last_col ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  generate
    for (genvar gi = 0; gi < ROW_PIX; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q[gi] <= '0;
        end else if (accept_i && (col_q == COL_W'(gi))) begin
          stage_q[gi] <= pix_i;
        end
      end
      assign row_o[gi*PIX_W +: PIX_W] = (col_q == COL_W'(gi)) ? pix_i : stage_q[gi];
    end
  endgenerate

endmodule

// File: rtl/image_row_server.sv
// Loads one image tile row by row, then serves any stored row combinationally.
// Storage only changes on a row commit, so partly loaded rows never appear on in_row.
module image_row_server #(
  parameter int PIX_W    = image_row_server_pkg::PIX_W,
  parameter int ROW_PIX  = image_row_server_pkg::ROW_PIX,
  parameter int NUM_ROWS = image_row_server_pkg::NUM_ROWS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     pix_ready,
  input  logic                     reload,
  input  logic [7:0]               next_row,
  output logic [PIX_W*ROW_PIX-1:0] in_row,
  output logic                     row_err,
  output logic                     frame_loaded,
  output logic                     interp_rst_n
);
  import image_row_server_pkg::*;

  localparam int ROW_BITS  = PIX_W * ROW_PIX;
  localparam int ROW_CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  state_e                state_q, state_d;
  logic [ROW_CNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic                  frame_loaded_q, frame_loaded_d;
  logic                  interp_rst_n_q;
  logic [ROW_BITS-1:0]   storage_q [NUM_ROWS];
  logic [ROW_BITS-1:0]   asm_row;
  logic                  commit;
  logic                  accept;

  assign pix_ready    = (state_q == ST_LOAD);
  // A reload in the same cycle as a transfer drops the sample.
  assign accept       = pix_valid && pix_ready && !reload;
  assign frame_loaded = frame_loaded_q;
  assign interp_rst_n = interp_rst_n_q;

  row_assembler #(
    .PIX_W   (PIX_W),
    .ROW_PIX (ROW_PIX)
  ) u_row_assembler (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (reload),
    .accept_i (accept),
    .pix_i    (pix_data),
    .row_o    (asm_row),
    .commit_o (commit)
  );

  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    frame_loaded_d = frame_loaded_q;
    if (reload) begin
      state_d        = ST_LOAD;
      row_cnt_d      = '0;
      frame_loaded_d = 1'b0;
    end else if (commit) begin
      if (row_cnt_q == ROW_CNT_W'(NUM_ROWS - 1)) begin
        state_d        = ST_SERVE;
        row_cnt_d      = '0;
        frame_loaded_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      row_cnt_q      <= '0;
      frame_loaded_q <= 1'b0;
      interp_rst_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_cnt_q      <= row_cnt_d;
      frame_loaded_q <= frame_loaded_d;
      interp_rst_n_q <= frame_loaded_q;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          storage_q[gi] <= '0;
        end else if (commit && (row_cnt_q == ROW_CNT_W'(gi))) begin
          storage_q[gi] <= asm_row;
        end
      end
    end
  endgenerate

  always_comb begin
    in_row  = '0;
    row_err = (int'(next_row) >= NUM_ROWS);
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (int'(next_row) == r) begin
        in_row = storage_q[r];
      end
    end
  end

endmodule

// File: tb/tb_image_row_server.sv
// Randomised scoreboard bench for image_row_server against a sample-count tile model.
module tb_image_row_server;
  localparam int PW = 8;
  localparam int RP = 15;
  localparam int NR = 15;
  localparam int NS = RP * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_ready;
  logic          reload;
  logic [7:0]    next_row;
  logic [PW*RP-1:0] in_row;
  logic          row_err;
  logic          frame_loaded;
  logic          interp_rst_n;

  always #5 clk = ~clk;

  image_row_server dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .reload       (reload),
    .next_row     (next_row),
    .in_row       (in_row),
    .row_err      (row_err),
    .frame_loaded (frame_loaded),
    .interp_rst_n (interp_rst_n)
  );

  typedef struct {
    int               kind;
    string            name;
    logic [PW*RP-1:0] exp_row;
    logic             exp_bit;
    int               idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference tile: samples indexed by arrival order; row = n / RP, col = n % RP.
  logic [7:0] m_mem [NR][RP];
  logic [7:0] m_buf [RP];
  int         m_cnt;
  bit         m_loaded;
  bit         m_irst;

  function automatic logic [PW*RP-1:0] model_row(input int r);
    logic [PW*RP-1:0] v;
    v = '0;
    if (r < NR) begin
      for (int c = 0; c < RP; c++) v[c*PW +: PW] = m_mem[r][c];
    end
    return v;
  endfunction

  function automatic logic [7:0] pat(input int n);
    return 8'((((n / RP) * 16) + (n % RP)) % 256);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < RP; c++) m_mem[r][c] = '0;
    for (int c = 0; c < RP; c++) m_buf[c] = '0;
    m_cnt    = 0;
    m_loaded = 1'b0;
    m_irst   = 1'b0;
  endtask

  task automatic push(input int k, input string n, input logic [PW*RP-1:0] r,
                      input logic b, input int idx);
    exp_t e;
    e.kind = k; e.name = n; e.exp_row = r; e.exp_bit = b; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic push_status();
    push(1, "frame_loaded", '0, m_loaded, 0);
    push(2, "pix_ready",    '0, !m_loaded, 0);
    push(3, "interp_rst_n", '0, m_irst, 0);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rl);
    pix_valid = v;
    pix_data  = d;
    reload    = rl;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_irst = m_loaded;
      if (rl) begin
        m_cnt    = 0;
        m_loaded = 1'b0;
      end else if (v && !m_loaded) begin
        m_buf[m_cnt % RP] = d;
        m_cnt++;
        if (m_cnt % RP == 0) begin
          for (int c = 0; c < RP; c++) m_mem[m_cnt / RP - 1][c] = m_buf[c];
        end
        if (m_cnt == NS) begin
          m_loaded = 1'b1;
          m_cnt    = 0;
        end
      end
    end
    push_status();
  endtask

  task automatic read(input int idx);
    next_row = 8'(idx);
    push(0, "in_row", model_row(idx), (idx >= NR), idx);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic read_all();
    for (int r = 0; r < NR; r++) read(r);
  endtask

  task automatic load(input bit use_pat, input bit random_gaps);
    int  guard;
    bit  v;
    guard = 0;
    while (!m_loaded && guard < 4000) begin
      v = random_gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      if (v) step(1'b1, use_pat ? pat(m_cnt) : 8'hAA, 1'b0);
      else   step(1'b0, 8'($urandom), 1'b0);
      guard++;
    end
    total++;
    if (!m_loaded) begin
      bad++;
      $display("FAIL load_timeout: got loaded=%0d want loaded=1", m_loaded);
    end
  endtask

  // Monitor: drains every expectation queued since the previous edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic got;
        e = sb.pop_front();
        total++;
        case (e.kind)
          0: begin
            if (in_row !== e.exp_row || row_err !== e.exp_bit) begin
              bad++;
              $display("FAIL %s[%0d]: got row=%h err=%b want row=%h err=%b",
                       e.name, e.idx, in_row, row_err, e.exp_row, e.exp_bit);
            end else begin
              $display("read row %0d: %h err=%b", e.idx, in_row, row_err);
            end
          end
          default: begin
            got = (e.kind == 1) ? frame_loaded : (e.kind == 2) ? pix_ready : interp_rst_n;
            if (got !== e.exp_bit) begin
              bad++;
              $display("FAIL %s: got %b want %b at %0t", e.name, got, e.exp_bit, $time);
            end
          end
        endcase
      end
    end
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; reload = 1'b0; next_row = '0;
    model_reset();
    step(1'b0, 8'h00, 1'b0);
    read(0);
    read(14);
    rst = 1'b0;

    // Gap-free pattern load, then range checks.
    load(1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    read_all();
    read(15);
    read(255);
    read(14);

    // SERVE ignores the loader.
    repeat (20) step(1'b1, 8'hFF, 1'b0);
    read_all();

    // Reload from SERVE, partial load, reload colliding with a sample, then 0xAA tile.
    step(1'b0, 8'h00, 1'b1);
    while (m_cnt < 100) step(1'b1, pat(m_cnt), 1'b0);
    read(10);
    read(0);
    step(1'b1, 8'h55, 1'b1);
    load(1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    read_all();

    // Random valid gaps.
    step(1'b0, 8'h00, 1'b1);
    load(1'b1, 1'b1);
    read_all();

    // Asynchronous reset mid row 7, then a fresh load.
    step(1'b0, 8'h00, 1'b1);
    while (m_cnt < 7 * RP + 6) step(1'b1, pat(m_cnt), 1'b0);
    #2;
    rst = 1'b1;
    next_row = 8'd7;
    model_reset();
    push(0, "in_row_rst", '0, 1'b0, 7);
    push_status();
    step(1'b1, pat(0), 1'b0);
    rst = 1'b0;
    load(1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    read_all();

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
